// File: rtl/bcd_pkg.sv
// Shared types and decode helper for the BCD digit stream path.
// Holds the entry layout that is stored in the output buffer.
package bcd_pkg;

   typedef logic [3:0] bcd_t;
   typedef logic [9:1] decimal_t;

   localparam bcd_t        BCD_MAX = 4'd9;
   localparam int unsigned ENTRY_W = 10;

   typedef struct packed {
      decimal_t decimal;
      logic     err;
   } entry_t;

   // Digit k in 1..9 lights line k; zero and illegal codes give no lines.
   function automatic decimal_t bcd_to_decimal(bcd_t d);
      decimal_t r;
      r = '0;
      case (d)
         4'd1:    r[1] = 1'b1;
         4'd2:    r[2] = 1'b1;
         4'd3:    r[3] = 1'b1;
         4'd4:    r[4] = 1'b1;
         4'd5:    r[5] = 1'b1;
         4'd6:    r[6] = 1'b1;
         4'd7:    r[7] = 1'b1;
         4'd8:    r[8] = 1'b1;
         4'd9:    r[9] = 1'b1;
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic bcd_is_illegal(bcd_t d);
      return d > BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_digit_fifo.sv
// DEPTH-entry buffer for decoded digits; the read port is the registered head.
// Occupancy is tracked by a count one bit wider than the wrapping pointers.
module bcd_digit_fifo
   import bcd_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = ENTRY_W
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: stale words are never visible while count says empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/bcd_decoder_stream.sv
// Streams 4-bit BCD digits into one-hot decimal lines [9:1] through a small buffer.
// Illegal codes pass through as all-zero with an error flag and a saturating count.
module bcd_decoder_stream
   import bcd_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic [3:0]       bcd_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [9:1]       decimal_out,
   output logic             out_err,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             clr_err,
   output logic [CNT_W-1:0] err_count
);

   logic   ready_q;
   logic   accept;
   logic   pop;
   logic   full;
   logic   empty;
   logic   illegal;
   entry_t wr_entry;
   entry_t rd_entry;

   assign illegal          = bcd_is_illegal(bcd_in);
   assign wr_entry.decimal = bcd_to_decimal(bcd_in);
   assign wr_entry.err     = illegal;

   // No pass-through: a full buffer refuses input even while the head is popped.
   assign in_ready  = ready_q && !full;
   assign out_valid = !empty;
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign decimal_out = empty ? '0 : rd_entry.decimal;
   assign out_err     = empty ? 1'b0 : rd_entry.err;

   bcd_digit_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rstN  (rstN),
      .push  (accept),
      .pop   (pop),
      .wdata (wr_entry),
      .rdata (rd_entry),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         ready_q   <= 1'b0;
         err_count <= '0;
      end else begin
         ready_q <= 1'b1;
         if (clr_err)
            err_count <= '0;
         else if (accept && illegal && (err_count != '1))
            err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_bcd_decoder_stream.sv
// Self-checking bench for bcd_decoder_stream: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_bcd_decoder_stream;

   localparam int DEPTH   = 2;
   localparam int CNT_W   = 8;
   localparam int ERR_MAX = (1 << CNT_W) - 1;

   logic       clk = 1'b0;
   logic       rstN;
   logic [3:0] bcd_in;
   logic       in_valid;
   logic       in_ready;
   logic [9:1] decimal_out;
   logic       out_err;
   logic       out_valid;
   logic       out_ready;
   logic       clr_err;
   logic [7:0] err_count;

   logic [3:0] s_bcd;
   logic       s_valid;
   logic       s_in_ready;
   logic [9:1] s_dec;
   logic       s_err;
   logic       s_out_valid;
   logic       s_out_ready;
   logic       s_clr;
   logic [1:0] s_cnt;

   int         n_checks = 0;
   int         n_fail   = 0;

   logic [9:0] q[$];
   logic [8:0] popped[$];
   int         m_err;
   bit         ready_en;

   always #5 clk = ~clk;

   bcd_decoder_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
      .clk(clk), .rstN(rstN), .bcd_in(bcd_in), .in_valid(in_valid), .in_ready(in_ready),
      .decimal_out(decimal_out), .out_err(out_err), .out_valid(out_valid),
      .out_ready(out_ready), .clr_err(clr_err), .err_count(err_count)
   );

   bcd_decoder_stream #(.DEPTH(2), .CNT_W(2)) u_sat (
      .clk(clk), .rstN(rstN), .bcd_in(s_bcd), .in_valid(s_valid), .in_ready(s_in_ready),
      .decimal_out(s_dec), .out_err(s_err), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .clr_err(s_clr), .err_count(s_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [9:0] ref_entry(int d);
      if (d > 9)  return {9'd0, 1'b1};
      if (d == 0) return 10'd0;
      return {9'(1 << (d - 1)), 1'b0};
   endfunction

   // One clock: compare outputs to the model, then advance the model across the edge.
   task automatic step(output bit acc);
      logic [9:0] head;
      bit         exp_ready;
      bit         pop;
      exp_ready = ready_en && (q.size() < DEPTH);
      head      = (q.size() > 0) ? q[0] : 10'd0;
      check("in_ready",    32'(in_ready),    32'(exp_ready));
      check("out_valid",   32'(out_valid),   32'(q.size() > 0));
      check("decimal_out", 32'(decimal_out), 32'(head[9:1]));
      check("out_err",     32'(out_err),     32'(head[0]));
      check("err_count",   32'(err_count),   32'(m_err));
      acc = in_valid && exp_ready;
      pop = (q.size() > 0) && out_ready;
      if (pop) popped.push_back(decimal_out);
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(ref_entry(int'(bcd_in)));
      if (clr_err)
         m_err = 0;
      else if (acc && bcd_in > 4'd9 && m_err < ERR_MAX)
         m_err++;
      ready_en = 1'b1;
      @(negedge clk);
   endtask

   task automatic send(input logic [3:0] d);
      bit acc;
      acc      = 1'b0;
      bcd_in   = d;
      in_valid = 1'b1;
      for (int i = 0; i < 64 && !acc; i++) step(acc);
      check("send_accepted", 32'(acc), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(acc);
   endtask

   initial begin
      bit         acc;
      bit         pending;
      logic [8:0] exp3 [3];

      rstN = 1'b0; bcd_in = '0; in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
      s_bcd = '0; s_valid = 1'b0; s_out_ready = 1'b1; s_clr = 1'b0;
      m_err = 0; ready_en = 1'b0;

      @(negedge clk);
      check("rst_out_valid", 32'(out_valid),   32'd0);
      check("rst_decimal",   32'(decimal_out), 32'd0);
      check("rst_out_err",   32'(out_err),     32'd0);
      check("rst_err_count", 32'(err_count),   32'd0);
      rstN = 1'b1;
      idle(1);

      // saturating counter on the narrow instance
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("sat_in_ready", 32'(s_in_ready), 32'd1);
         s_bcd   = 4'(10 + i);
         s_valid = 1'b1;
         @(posedge clk); @(negedge clk);
         check("sat_count", 32'(s_cnt), 32'((i + 1 > 3) ? 3 : i + 1));
      end
      s_bcd = 4'hF; s_clr = 1'b1;
      @(posedge clk); @(negedge clk);
      check("sat_clr_prio", 32'(s_cnt), 32'd0);
      s_valid = 1'b0; s_clr = 1'b0;

      // digits 0..9 with consumer always ready
      out_ready = 1'b1;
      for (int d = 0; d <= 9; d++) send(4'(d));
      idle(2);

      // illegal codes A..F
      for (int d = 10; d <= 15; d++) send(4'(d));
      idle(2);
      check("t2_err_count", 32'(err_count), 32'd6);

      // backpressure: 3, 7 fill the buffer, 5 waits
      popped.delete();
      out_ready = 1'b0;
      send(4'd3);
      send(4'd7);
      bcd_in = 4'd5; in_valid = 1'b1;
      idle(2);
      check("t3_held_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      send(4'd5);
      idle(3);
      exp3 = '{9'h004, 9'h040, 9'h010};
      check("t3_pop_count", 32'(popped.size()), 32'd3);
      for (int i = 0; i < 3 && i < popped.size(); i++)
         check("t3_order", 32'(popped[i]), 32'(exp3[i]));

      // simultaneous push and pop at count 1
      out_ready = 1'b0;
      send(4'd2);
      out_ready = 1'b1;
      send(4'd8);
      check("t5_head",  32'(decimal_out), 32'h080);
      check("t5_valid", 32'(out_valid),   32'd1);
      check("t5_ready", 32'(in_ready),    32'd1);
      idle(2);

      // asynchronous reset in the middle of the low phase with two entries buffered
      out_ready = 1'b0;
      send(4'd1);
      send(4'd4);
      #2 rstN = 1'b0;
      #1;
      check("t6_out_valid", 32'(out_valid),   32'd0);
      check("t6_decimal",   32'(decimal_out), 32'd0);
      check("t6_err_count", 32'(err_count),   32'd0);
      q.delete(); m_err = 0; ready_en = 1'b0;
      @(posedge clk); @(negedge clk);
      rstN = 1'b1;
      out_ready = 1'b1;
      idle(4);

      // random traffic; producer holds a digit until it is taken
      pending = 1'b0;
      for (int n = 0; n < 500; n++) begin
         if (!pending) begin
            if ($urandom_range(0, 3) != 0) begin
               bcd_in   = 4'($urandom_range(0, 15));
               in_valid = 1'b1;
               pending  = 1'b1;
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = ($urandom_range(0, 2) != 0);
         clr_err   = ($urandom_range(0, 29) == 0);
         step(acc);
         if (acc) pending = 1'b0;
      end
      in_valid = 1'b0; clr_err = 1'b0; out_ready = 1'b1;
      idle(DEPTH + 2);
      check("final_empty", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
